// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction-fetch responder with fixed read latency
//
// Accepts one fetch request (byte address) and returns the addressed 32-bit
// instruction word LATENCY edges later over a valid/ready handshake. A flush
// cancels the outstanding fetch or pending response.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  fetch request present
//   req_addr   byte address of the requested instruction
//   req_ready  request can be accepted this cycle (combinational)
//   flush      cancel outstanding request/response
//   rsp_valid  response present
//   rsp_ready  fetch stage consumes the response this cycle
//   rsp_addr   address of the request being answered
//   rsp_instr  instruction word, 0 when rsp_err=1
//   rsp_err    request was misaligned or out of range
module inst_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_instr,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  localparam logic [31:0] LIMIT   = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic        rsp_err_q, rsp_err_d;

  // Default instruction image: word i holds the value i.
  logic [31:0] rom [DEPTH_WORDS];
  for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_rom
    assign rom[i] = 32'(i);
  end

  logic [AW-1:0] rd_idx;
  logic          addr_err;

  assign rd_idx   = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT);

  assign req_ready = (state_q == IDLE) && !flush && rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Flush wins over a read completing on the same edge; data outputs keep old values.
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_err_d   = addr_err;
          rsp_instr_d = addr_err ? 32'd0 : rom[rd_idx];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (flush || rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 32'd0;
      rsp_instr_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - bench for inst_mem_responder at LATENCY 2, 1 and 7
module tb_inst_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_ready;

  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_addr  [3];
  logic [31:0] rsp_instr [3];

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  inst_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready[0]), .flush(flush), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready), .rsp_addr(rsp_addr[0]), .rsp_instr(rsp_instr[0]),
    .rsp_err(rsp_err[0]));

  inst_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready[1]), .flush(flush), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready), .rsp_addr(rsp_addr[1]), .rsp_instr(rsp_instr[1]),
    .rsp_err(rsp_err[1]));

  inst_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready[2]), .flush(flush), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready), .rsp_addr(rsp_addr[2]), .rsp_instr(rsp_instr[2]),
    .rsp_err(rsp_err[2]));

  function automatic int lat_of(int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic bit is_err(bit [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d got %h want %h at %0t", name, k, act, exp, $time);
  endtask

  // Model: a request is pending until its due edge (acceptance edge + LATENCY),
  // then the response is shown until consumed or flushed.
  bit [31:0] m_cyc = 0;
  bit        m_pending [3];
  bit [31:0] m_due     [3];
  bit [31:0] m_req     [3];
  bit        m_valid   [3];
  bit [31:0] m_addr    [3];
  bit [31:0] m_instr   [3];
  bit        m_err     [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_pending[k] <= 1'b0;
        m_valid[k]   <= 1'b0;
        m_addr[k]    <= '0;
        m_instr[k]   <= '0;
        m_err[k]     <= 1'b0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      for (int k = 0; k < 3; k++) begin
        if (m_valid[k]) begin
          if (rsp_ready || flush) m_valid[k] <= 1'b0;
        end else if (m_pending[k]) begin
          if (flush) begin
            m_pending[k] <= 1'b0;
          end else if (m_cyc + 1 == m_due[k]) begin
            m_pending[k] <= 1'b0;
            m_valid[k]   <= 1'b1;
            m_addr[k]    <= m_req[k];
            m_err[k]     <= is_err(m_req[k]);
            m_instr[k]   <= is_err(m_req[k]) ? 32'd0 : m_req[k] / 4;
          end
        end else if (req_valid && !flush) begin
          m_pending[k] <= 1'b1;
          m_req[k]     <= req_addr;
          m_due[k]     <= m_cyc + 1 + 32'(lat_of(k));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 3; k++) begin
        chk("req_ready", k, 32'(req_ready[k]),
            32'(rst_n && !flush && !m_pending[k] && !m_valid[k]));
        chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_valid[k]));
        chk("rsp_addr",  k, rsp_addr[k],  m_addr[k]);
        chk("rsp_instr", k, rsp_instr[k], m_instr[k]);
        chk("rsp_err",   k, 32'(rsp_err[k]), 32'(m_err[k]));
      end
    end
  end

  bit [31:0] e_acc;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    e_acc     = m_cyc;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    while (req_ready != 3'b111 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_done", 0, 32'(req_ready), 32'h7);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    tick();
    tick();
    #1;
    chk("reset_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("reset_ready", 0, 32'(req_ready[0]), 32'd0);
    chk("reset_instr", 0, rsp_instr[0], 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 0, 32'(req_ready[0]), 32'd1);

    // Basic fetch and latency sweep.
    issue(32'h8);
    #1 chk("busy_after_accept", 0, 32'(req_ready[0]), 32'd0);
    tick();
    #1 chk("l2_not_yet", 0, 32'(rsp_valid[0]), 32'd0);
    chk("l1_valid_e1", 1, 32'(rsp_valid[1]), 32'd1);
    chk("l1_instr", 1, rsp_instr[1], 32'h2);
    tick();
    #1 chk("l2_valid_e2", 0, 32'(rsp_valid[0]), 32'd1);
    chk("l2_instr", 0, rsp_instr[0], 32'h2);
    chk("l2_addr", 0, rsp_addr[0], 32'h8);
    chk("l2_err", 0, 32'(rsp_err[0]), 32'd0);
    n = 0;
    while (!rsp_valid[2] && n < 12) begin
      tick();
      n++;
    end
    chk("l7_latency", 2, m_cyc - e_acc, 32'd7);
    chk("l7_instr", 2, rsp_instr[2], 32'h2);
    drain();

    // Back-pressure.
    issue(32'h10);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("bp_instr", 0, rsp_instr[0], 32'h4);
      chk("bp_addr", 0, rsp_addr[0], 32'h10);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1 chk("bp_done_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("bp_done_ready", 0, 32'(req_ready[0]), 32'd1);
    drain();

    // Errors.
    issue(32'h6);
    tick();
    tick();
    #1 chk("mis_err", 0, 32'(rsp_err[0]), 32'd1);
    chk("mis_instr", 0, rsp_instr[0], 32'd0);
    chk("mis_addr", 0, rsp_addr[0], 32'h6);
    drain();
    issue(32'h1000);
    tick();
    tick();
    #1 chk("oor_err", 0, 32'(rsp_err[0]), 32'd1);
    chk("oor_instr", 0, rsp_instr[0], 32'd0);
    chk("oor_addr", 0, rsp_addr[0], 32'h1000);
    drain();

    // Flush in WAIT, then a fresh fetch.
    issue(32'hC);
    flush = 1'b1;
    #1 chk("flush_ready", 0, 32'(req_ready[0]), 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("flushed_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
    end
    issue(32'h4);
    tick();
    #1 chk("post_flush_e1", 0, 32'(rsp_valid[0]), 32'd0);
    tick();
    #1 chk("post_flush_valid", 0, 32'(rsp_valid[0]), 32'd1);
    chk("post_flush_instr", 0, rsp_instr[0], 32'h1);
    drain();

    // Flush coincident with handshake, then flush in IDLE.
    issue(32'h20);
    tick();
    tick();
    flush = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
    rsp_ready = 1'b0;
    #1 chk("coll_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("coll_ready", 0, 32'(req_ready[0]), 32'd1);
    tick();
    #1 chk("coll_once", 0, 32'(rsp_valid[0]), 32'd0);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h30;
    #1 chk("idle_flush_ready", 0, 32'(req_ready[0]), 32'd0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    #1 chk("idle_flush_noacc", 0, 32'(rsp_valid[0]), 32'd0);
    chk("idle_flush_idle", 0, 32'(req_ready[0]), 32'd1);

    // Asynchronous reset during WAIT.
    chk("pre_reset_addr", 0, rsp_addr[0], 32'h20);
    issue(32'h40);
    rst_n = 1'b0;
    #1 chk("arst_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("arst_addr", 0, rsp_addr[0], 32'd0);
    chk("arst_instr", 0, rsp_instr[0], 32'd0);
    chk("arst_ready", 0, 32'(req_ready[0]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1 chk("arst_no_rsp_l2", 0, 32'(rsp_valid[0]), 32'd0);
      chk("arst_no_rsp_l7", 2, 32'(rsp_valid[2]), 32'd0);
    end
    issue(32'h8);
    tick();
    tick();
    #1 chk("recover_instr", 0, rsp_instr[0], 32'h2);
    drain();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder end of the instruction-fetch interface: accepts one fetch request (byte address) from the fetch stage and returns the addressed 32-bit instruction word after a fixed, parameterised latency.
- Sits between the IF stage and instruction storage, replacing the zero-latency array lookup with a valid/ready handshake.
- Supports pipeline flush, which cancels the outstanding fetch.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the instruction store (power of 2).
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_addr  input  32  byte address of the requested instruction.
- req_ready  output  1  responder can accept a request this cycle.
- flush  input  1  cancel any outstanding request or response.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  fetch stage consumes the response this cycle.
- rsp_addr  output  32  address of the request being answered.
- rsp_instr  output  32  instruction word; 0 when rsp_err=1.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Storage: DEPTH_WORDS x 32 array, read-only to this block, indexed by req_addr[log2(DEPTH_WORDS)+1:2].
  - Simulation initialisation sets word i = i; program images overwrite selected words at time 0.
  - rst does not alter contents.
- Error rule: rsp_err=1 if req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS. With rsp_err=1, rsp_instr=0 and rsp_addr is still returned.
- States: IDLE, WAIT, RESP. Single outstanding request.
- req_ready = (state==IDLE) && !flush && rst. It is combinational and 0 during reset.
- Accept: at a rising edge where req_valid && req_ready.
  - Latch req_addr.
  - Load a 3-bit counter with LATENCY-1.
  - Go to WAIT.
- WAIT: the counter decrements each edge. On the edge where the counter is 0:
  - Read the array.
  - Register rsp_instr, rsp_addr and rsp_err.
  - Set rsp_valid=1 and go to RESP.
  - Net result: rsp_valid rises exactly LATENCY edges after the acceptance edge (LATENCY=1 gives rsp_valid the cycle after acceptance).
- RESP: rsp_valid, rsp_addr, rsp_instr and rsp_err hold stable until rsp_valid && rsp_ready at an edge.
  - Then clear rsp_valid and return to IDLE.
  - req_ready is 1 in the following cycle (no back-to-back accept in the handshake cycle).
- Flush, sampled at the edge:
  - In WAIT or RESP: go to IDLE and clear rsp_valid. Data outputs keep their last values.
  - In IDLE: no acceptance that cycle.
  - Flush coincident with a RESP handshake: the handshake counts as completed; the next state is IDLE.
- Reset: asynchronous on rst falling.
  - State=IDLE, counter=0, rsp_valid=0, rsp_addr=0, rsp_instr=0, rsp_err=0.
  - Reset mid-WAIT or mid-RESP discards the request with no response.
  - Leaving reset: req_ready=1 in the first cycle with rst=1 and flush=0.
- Outputs other than req_ready are registered; there are no combinational paths from req_* to rsp_*.

Test Plan:
- Basic fetch, LATENCY=2, default init:
  - Stimulus: req_addr=0x8 accepted at edge E.
  - Response: rsp_valid=1 after edge E+2, rsp_instr=0x2, rsp_addr=0x8, rsp_err=0. req_ready=0 from E+1 until after the handshake edge.
- Back-pressure:
  - Stimulus: rsp_ready held 0 for 5 cycles after rsp_valid rises, on a request to 0x10.
  - Response: rsp_valid, rsp_instr=0x4 and rsp_addr stay stable for all 5 cycles. After rsp_ready=1 at edge H, rsp_valid=0 and req_ready=1 after H.
- Errors:
  - req_addr=0x6 gives rsp_err=1, rsp_instr=0, rsp_addr=0x6.
  - req_addr=0x1000 (DEPTH_WORDS=1024) gives rsp_err=1, rsp_instr=0.
- Flush in WAIT:
  - Stimulus: accept 0xC, then flush=1 one cycle later.
  - Response: rsp_valid never rises for 0xC. A new request to 0x4 issued after the flush returns 0x1 with correct timing.
- Flush/handshake collision and flush in IDLE:
  - flush=1 and rsp_ready=1 in the same RESP cycle: the response is consumed exactly once and the state is IDLE.
  - flush=1 with req_valid=1 in IDLE: req_ready=0 and no acceptance.
- Async reset mid-operation:
  - Stimulus: rst driven low between clock edges during WAIT.
  - Response: rsp_valid=0, rsp_addr=0, rsp_instr=0 immediately, with no response after rst returns high.
  - Sweep LATENCY=1 and LATENCY=7 with timing checked per the acceptance rule.
